// File: rtl/apb_uart_regs.sv
// Zero-wait APB2 register block for the UART: CTRL/STATUS plus TX and RX byte FIFOs; reads registered into PRDATA.
// Optional interrupt output and CTRL[7:4] mask when APB_UART_IRQ_EN is defined.
module apb_uart_regs #(
  parameter int          PADDR_WIDTH  = 8,
  parameter int          PDATA_WIDTH  = 32,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [15:0] BAUD_DIV_RST = 16'd27
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic                   PSEL,
  input  logic                   PENABLE,
  input  logic                   PWRITE,
  input  logic [PADDR_WIDTH-1:0] PADDR,
  input  logic [PDATA_WIDTH-1:0] PWDATA,
  output logic [PDATA_WIDTH-1:0] PRDATA,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   tx_en,
  output logic                   rx_en,
`ifdef APB_UART_IRQ_EN
  output logic                   irq,
`endif
  output logic [15:0]            baud_div
);

  localparam int            PW       = $clog2(FIFO_DEPTH);
  localparam int            CW       = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t        state;
  logic [1:0]    a_addr;
  logic          a_write;

  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wp, tx_rp;
  logic [CW-1:0] tx_cnt;
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [PW-1:0] rx_wp, rx_rp;
  logic [CW-1:0] rx_cnt;

  logic          tx_ovf, rx_ovf, rx_unf;
  logic [31:0]   status_rd, ctrl_rd, rdata;

`ifdef APB_UART_IRQ_EN
  logic [3:0]    irq_mask;
`endif

  logic commit, tx_full, tx_empty, rx_full, rx_empty;
  logic wr_tx, rd_rx, wr_st, wr_ctrl;
  logic tx_push, tx_pop, rx_req, rx_pop, rx_push;
  logic unused_in;

  assign unused_in = ^{PADDR, PWDATA};

  // Every ACCESS cycle ends in exactly one commit edge (zero wait states).
  assign commit   = (state == ACCESS);
  assign tx_full  = (tx_cnt == FULL_CNT);
  assign tx_empty = (tx_cnt == '0);
  assign rx_full  = (rx_cnt == FULL_CNT);
  assign rx_empty = (rx_cnt == '0);

  assign wr_tx    = commit &  a_write & (a_addr == 2'd0);
  assign rd_rx    = commit & !a_write & (a_addr == 2'd1);
  assign wr_st    = commit &  a_write & (a_addr == 2'd2);
  assign wr_ctrl  = commit &  a_write & (a_addr == 2'd3);

  assign tx_valid = tx_en & !tx_empty;
  assign tx_data  = tx_mem[tx_rp];
  assign tx_push  = wr_tx & !tx_full;
  assign tx_pop   = tx_valid & tx_ready;

  // A full RX FIFO still accepts a byte when an APB pop commits on the same edge.
  assign rx_req   = rx_valid & rx_en;
  assign rx_pop   = rd_rx & !rx_empty;
  assign rx_push  = rx_req & (!rx_full | rx_pop);

  always_comb begin
    status_rd        = '0;
    status_rd[0]     = tx_full;
    status_rd[1]     = tx_empty;
    status_rd[2]     = rx_full;
    status_rd[3]     = rx_empty;
    status_rd[4]     = tx_ovf;
    status_rd[5]     = rx_ovf;
    status_rd[6]     = rx_unf;
    status_rd[12:8]  = 5'(tx_cnt);
    status_rd[20:16] = 5'(rx_cnt);

    ctrl_rd          = '0;
    ctrl_rd[0]       = tx_en;
    ctrl_rd[1]       = rx_en;
    ctrl_rd[31:16]   = baud_div;
`ifdef APB_UART_IRQ_EN
    ctrl_rd[7:4]     = irq_mask;
`endif

    case (a_addr)
      2'd1:    rdata = rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rp]};
      2'd2:    rdata = status_rd;
      2'd3:    rdata = ctrl_rd;
      default: rdata = 32'd0;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state   <= IDLE;
      a_addr  <= 2'd0;
      a_write <= 1'b0;
      PRDATA  <= '0;
    end else begin
      case (state)
        IDLE, ACCESS: begin
          if (PSEL && !PENABLE) begin
            state   <= SETUP;
            a_addr  <= PADDR[3:2];
            a_write <= PWRITE;
          end else begin
            state   <= IDLE;
          end
        end
        SETUP: begin
          if (PSEL && PENABLE) begin
            state  <= ACCESS;
            PRDATA <= a_write ? '0 : PDATA_WIDTH'(rdata);
          end else begin
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tx_en    <= 1'b0;
      rx_en    <= 1'b0;
      baud_div <= BAUD_DIV_RST;
`ifdef APB_UART_IRQ_EN
      irq_mask <= 4'd0;
`endif
    end else if (wr_ctrl) begin
      tx_en    <= PWDATA[0];
      rx_en    <= PWDATA[1];
      baud_div <= PWDATA[31:16];
`ifdef APB_UART_IRQ_EN
      irq_mask <= PWDATA[7:4];
`endif
    end
  end

  // Sticky flags: write-1-to-clear, a same-edge set takes priority.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tx_ovf <= 1'b0;
      rx_ovf <= 1'b0;
      rx_unf <= 1'b0;
    end else begin
      tx_ovf <= (tx_ovf & !(wr_st & PWDATA[4])) | (wr_tx & tx_full);
      rx_ovf <= (rx_ovf & !(wr_st & PWDATA[5])) | (rx_req & rx_full & !rx_pop);
      rx_unf <= (rx_unf & !(wr_st & PWDATA[6])) | (rd_rx & rx_empty);
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
    end
  end

  always_ff @(posedge PCLK) begin
    if (tx_push) tx_mem[tx_wp] <= PWDATA[7:0];
    if (rx_push) rx_mem[rx_wp] <= rx_data;
  end

`ifdef APB_UART_IRQ_EN
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) irq <= 1'b0;
    else          irq <= |(irq_mask & {rx_unf, tx_ovf | rx_ovf, !rx_empty, tx_empty});
  end
`endif

endmodule

// File: tb/tb_apb_uart_regs.sv
// Scoreboard bench for apb_uart_regs: APB reads and TX bytes are checked against queued expectations.
`timescale 1ns/1ps
module tb_apb_uart_regs;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [7:0]  PADDR = 8'd0;
  logic [31:0] PWDATA = 32'd0;
  logic [31:0] PRDATA;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        tx_en, rx_en;
  logic [15:0] baud_div;
`ifdef APB_UART_IRQ_EN
  logic        irq;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] exp_q[$];
  logic [31:0] tx_q[$];
  logic [7:0]  rx_q[$];
  logic        m_tx_ovf = 1'b0, m_rx_ovf = 1'b0, m_rx_unf = 1'b0;
  logic [31:0] m_ctrl = 32'h001B_0000;
  logic [31:0] tx_exp;

  apb_uart_regs dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_en(tx_en), .rx_en(rx_en),
`ifdef APB_UART_IRQ_EN
    .irq(irq),
`endif
    .baud_div(baud_div)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s = 32'd0;
    s[0]     = (tx_q.size() == 8);
    s[1]     = (tx_q.size() == 0);
    s[2]     = (rx_q.size() == 8);
    s[3]     = (rx_q.size() == 0);
    s[4]     = m_tx_ovf;
    s[5]     = m_rx_ovf;
    s[6]     = m_rx_unf;
    s[12:8]  = 5'(tx_q.size());
    s[20:16] = 5'(rx_q.size());
    return s;
  endfunction

  function automatic logic [31:0] ctrl_of(input logic [31:0] d);
    logic [31:0] c = 32'd0;
    c[31:16] = d[31:16];
    c[1:0]   = d[1:0];
`ifdef APB_UART_IRQ_EN
    c[7:4]   = d[7:4];
`endif
    return c;
  endfunction

  // Transmitter side: every handshake must deliver the oldest accepted byte.
  always @(negedge PCLK) begin
    #3;
    if (PRESETn && tx_valid && tx_ready) begin
      tx_exp = (tx_q.size() != 0) ? tx_q.pop_front() : 32'hDEAD_BEEF;
      check("tx_byte", {24'd0, tx_data}, tx_exp);
    end
  end

  task automatic apb_xfer(input logic w, input logic [7:0] a, input logic [31:0] d,
                          input logic strobe, input logic [7:0] sb, output logic [31:0] rd);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    rd = PRDATA;
    PSEL = 1'b0; PENABLE = 1'b0;
    if (strobe) begin
      rx_valid = 1'b1; rx_data = sb;
      @(negedge PCLK);
      rx_valid = 1'b0;
    end
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] rd;
    case (a[3:2])
      2'd0: if (tx_q.size() < 8) tx_q.push_back({24'd0, d[7:0]}); else m_tx_ovf = 1'b1;
      2'd2: begin
        if (d[4]) m_tx_ovf = 1'b0;
        if (d[5]) m_rx_ovf = 1'b0;
        if (d[6]) m_rx_unf = 1'b0;
      end
      2'd3: m_ctrl = ctrl_of(d);
      default: ;
    endcase
    apb_xfer(1'b1, a, d, 1'b0, 8'd0, rd);
  endtask

  task automatic apb_read(input string tag, input logic [7:0] a, input logic [31:0] exp,
                          input logic strobe, input logic [7:0] sb);
    logic [31:0] rd;
    exp_q.push_back(exp);
    apb_xfer(1'b0, a, 32'd0, strobe, sb, rd);
    check(tag, rd, exp_q.pop_front());
  endtask

  task automatic rx_read(input string tag, input logic [7:0] a, input logic strobe, input logic [7:0] sb);
    logic [31:0] e;
    if (rx_q.size() != 0) e = {24'd0, rx_q.pop_front()};
    else begin e = 32'd0; m_rx_unf = 1'b1; end
    if (strobe && m_ctrl[1]) begin
      if (rx_q.size() < 8) rx_q.push_back(sb); else m_rx_ovf = 1'b1;
    end
    apb_read(tag, a, e, strobe, sb);
  endtask

  task automatic send_rx(input logic [7:0] b);
    if (m_ctrl[1]) begin
      if (rx_q.size() < 8) rx_q.push_back(b); else m_rx_ovf = 1'b1;
    end
    @(negedge PCLK); rx_valid = 1'b1; rx_data = b;
    @(negedge PCLK); rx_valid = 1'b0;
  endtask

  task automatic drain();
    tx_ready = 1'b1;
    for (int i = 0; i < 40 && tx_q.size() != 0; i++) @(negedge PCLK);
    @(negedge PCLK);
    tx_ready = 1'b0;
    check("tx_drained", 32'(tx_q.size()), 32'd0);
    check("tx_valid_idle", 32'(tx_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge PCLK);
    check("rst_prdata", PRDATA, 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_en", {30'd0, rx_en, tx_en}, 32'd0);
    check("rst_baud", 32'(baud_div), 32'd27);
    PRESETn = 1'b1;
    apb_read("rst_status", 8'h08, exp_status(), 1'b0, 8'd0);
    apb_read("rst_ctrl", 8'h0C, m_ctrl, 1'b0, 8'd0);

    // CTRL: reserved bits ignored, enables and divisor visible on outputs.
    apb_write(8'h0C, 32'h001B_FFF3);
    apb_read("ctrl_rb", 8'h0C, m_ctrl, 1'b0, 8'd0);
    @(negedge PCLK);
    check("ctrl_out", {baud_div, 14'd0, rx_en, tx_en}, 32'h001B_0003);

    // TX overflow with the transmitter stalled.
    for (int i = 0; i < 9; i++) apb_write(8'h00, 32'h41 + i);
    apb_read("tx_full_status", 8'h08, exp_status(), 1'b0, 8'd0);
    apb_read("txdata_rd", 8'h00, 32'd0, 1'b0, 8'd0);
    apb_write(8'h08, 32'h10);
    apb_read("tx_ovf_w1c", 8'h08, exp_status(), 1'b0, 8'd0);

    // tx_en=0 holds the FIFO even with tx_ready high.
    apb_write(8'h0C, 32'h001B_0002);
    tx_ready = 1'b1;
    repeat (4) @(negedge PCLK);
    check("tx_hold_valid", 32'(tx_valid), 32'd0);
    apb_read("tx_hold_status", 8'h08, exp_status(), 1'b0, 8'd0);
    apb_write(8'h0C, 32'h001B_0003);
    drain();
    apb_read("tx_empty_status", 8'h08, exp_status(), 1'b0, 8'd0);

    // RX: two bytes, then an underflowing third read; W1C clears rx_unf.
    send_rx(8'h55);
    send_rx(8'hAA);
    apb_write(8'h04, 32'hFF);
    rx_read("rx_0", 8'h04, 1'b0, 8'd0);
    rx_read("rx_1", 8'hF4, 1'b0, 8'd0);
    rx_read("rx_unf_rd", 8'h04, 1'b0, 8'd0);
    apb_read("rx_unf_status", 8'h08, exp_status(), 1'b0, 8'd0);
    apb_write(8'h08, 32'h40);
    apb_read("rx_unf_clr", 8'h08, exp_status(), 1'b0, 8'd0);

    // rx_en=0 drops incoming bytes silently.
    apb_write(8'h0C, 32'h001B_0001);
    send_rx(8'h77);
    apb_read("rx_dis_status", 8'h08, exp_status(), 1'b0, 8'd0);
    apb_write(8'h0C, 32'h001B_0003);

    // RX fill, overflow, then full + same-edge pop accepts the new byte.
    for (int i = 0; i < 9; i++) send_rx(8'h10 + 8'(i));
    apb_read("rx_ovf_status", 8'h08, exp_status(), 1'b0, 8'd0);
    apb_write(8'h08, 32'h20);
    rx_read("rx_pop_push", 8'h04, 1'b1, 8'h99);
    apb_read("rx_same_edge", 8'h08, exp_status(), 1'b0, 8'd0);
    for (int i = 0; i < 8; i++) rx_read("rx_drain", 8'h04, 1'b0, 8'd0);
    apb_read("rx_drained", 8'h08, exp_status(), 1'b0, 8'd0);

    // Access phase without a setup cycle must not commit.
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 32'h5A;
    repeat (2) @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
    apb_read("no_setup", 8'h08, exp_status(), 1'b0, 8'd0);

    // Reset in the middle of an access with three TX bytes pending.
    apb_write(8'h0C, 32'h0100_0001);
    for (int i = 0; i < 3; i++) apb_write(8'h00, 32'h60 + i);
    apb_read("tx3_status", 8'h08, exp_status(), 1'b0, 8'd0);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h0C;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    check("ctrl_access", PRDATA, m_ctrl);
    #1 PRESETn = 1'b0;
    #1;
    check("arst_prdata", PRDATA, 32'd0);
    check("arst_baud", 32'(baud_div), 32'd27);
    check("arst_tx_valid", 32'(tx_valid), 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    tx_q.delete();
    rx_q.delete();
    m_tx_ovf = 1'b0; m_rx_ovf = 1'b0; m_rx_unf = 1'b0;
    m_ctrl = 32'h001B_0000;
    apb_read("arst_status", 8'h08, exp_status(), 1'b0, 8'd0);
    apb_read("arst_ctrl", 8'h0C, m_ctrl, 1'b0, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
